fetch_decode_reg: RTL and testbench
===================================

Name: fetch_decode_reg

Overview:
- F→D pipeline register of the 5-stage MIPS core. Sits directly downstream of the fetch PC register and instruction memory; feeds the decode stage.
- Latches the fetch PC, instruction and delay-slot flag each cycle.
- Detects fetch-address exceptions (AdEL) and carries the code forward.
- Implements stall hold, exception-flush bubbles and eret-delay-slot squash.

Parameters:
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).
- EXC_VEC, 32'h0000_4180, PC value carried by a flush bubble.
- EXC_ADEL, 5'd4, exception code for a bad fetch address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  1 = advance; 0 = stall and hold contents.
- req  in  1  exception/interrupt taken this cycle; flush to bubble.
- eretD  in  1  eret currently in D; squash the instruction being fetched.
- pcF  in  32  fetch PC.
- instrF  in  32  instruction read at pcF.
- bdF  in  1  instruction in F is a branch/jump delay slot.
- pcD  out  32  decode PC.
- instrD  out  32  decode instruction (0 = nop).
- excCodeD  out  5  fetch exception code (0 = none).
- bdD  out  1  delay-slot flag in D.
- validD  out  1  D holds a real (non-bubble) instruction.
- stallCnt  out  32  stall-cycle counter (see Optional Feature).
- squashCnt  out  32  flush+squash counter (see Optional Feature).

Behaviour:
- Reset values: pcD = IM_BASE, instrD = 0, excCodeD = 0, bdD = 0, validD = 0.
- All updates occur on posedge clk. Latency F→D is 1 cycle. Outputs are registered only; no combinational path from inputs to outputs.
- Fetch check (combinational, internal): adelF = (pcF[1:0] != 0) || (pcF < IM_BASE) || (pcF > IM_LIMIT). Comparisons are unsigned, 32-bit.
- Priority per cycle, highest first:
  1. reset → reset values.
  2. req → bubble: pcD = EXC_VEC, instrD = 0, excCodeD = 0, bdD = 0, validD = 0. Applies even when en = 0.
  3. en = 0 → hold all outputs. eretD is ignored, because the eret itself is also held in D.
  4. eretD → squash: pcD = pcF, instrD = 0, excCodeD = 0 (a fetch fault on the squashed slot is suppressed), bdD = 0, validD = 0.
  5. Normal load, adelF = 0: pcD = pcF, instrD = instrF, excCodeD = 0, bdD = bdF, validD = 1.
  6. Normal load, adelF = 1: pcD = pcF, instrD = 0, excCodeD = EXC_ADEL, bdD = bdF, validD = 1.
- The faulting PC is preserved in pcD so EPC computes correctly; bdD marks the delay slot so EPC = pcD − 4 downstream.
- Consecutive stalls hold indefinitely. The first cycle with en = 1 loads current F.
- req arriving mid-stall breaks the stall immediately.
- Reset asserted mid-stall or mid-req clears everything next edge. Counters also clear.

Optional Feature:
- Macro FD_PERF_CNT_EN.
- Defined:
  - stallCnt increments each cycle where en = 0 and req = 0 and reset = 0.
  - squashCnt increments each cycle where req = 1, or en = 1 with eretD = 1.
  - Both are 32-bit, wrap from 32'hFFFF_FFFF to 0, and clear on reset.
- Undefined: no counter flops; stallCnt and squashCnt are tied to 0. Ports remain present.

Decomposition:
- Shared package/define file: IM_BASE, IM_LIMIT, EXC_VEC, EXC_ADEL, exception-code constants (Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12), NOP = 32'h0.
- One sub-module is natural: fd_perf_cnt (two saturation-free 32-bit counters). It is instantiated only under FD_PERF_CNT_EN.

Test Plan:
- Reset, then pcF = 0x3000, instrF = 0x3C010001, en = 1 → next cycle pcD = 0x3000, instrD = 0x3C010001, validD = 1, excCodeD = 0.
- en = 0 for 3 cycles while pcF changes to 0x3004/0x3008 → pcD stays 0x3000. With the macro defined, stallCnt = 3.
- pcF = 0x3002, en = 1 → excCodeD = 4, instrD = 0, pcD = 0x3002. Repeat with pcF = 0x2FFC and then 0x7000 → excCodeD = 4 each time.
- req = 1 with en = 0 → pcD = 0x4180, instrD = 0, validD = 0, bdD = 0. squashCnt increments.
- eretD = 1, en = 1, pcF = 0x3010 (misaligned variant 0x3011 also) → instrD = 0, excCodeD = 0, validD = 0. eretD = 1 with en = 0 → hold.
- bdF = 1, pcF = 0x3020, en = 1 → bdD = 1. Reset asserted the same cycle as req → reset values win (pcD = 0x3000).

Source files
------------

// File: rtl/fetch_decode_reg_pkg.sv
// fetch_decode_reg_pkg: shared constants for the F->D pipeline register
package fetch_decode_reg_pkg;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [31:0] NOP      = 32'h0;
   localparam logic [4:0]  EXC_INT  = 5'd0;
   localparam logic [4:0]  EXC_ADEL = 5'd4;
   localparam logic [4:0]  EXC_ADES = 5'd5;
   localparam logic [4:0]  EXC_RI   = 5'd10;
   localparam logic [4:0]  EXC_OV   = 5'd12;
   function automatic logic fetch_adel(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
   endfunction
endpackage

// File: rtl/fetch_decode_reg_perf_cnt.sv
// fd_perf_cnt: free-running wrapping stall and squash event counters
module fd_perf_cnt (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_inc_i,
   input  logic        squash_inc_i,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] squash_cnt_o
);
   logic [31:0] stall_q, squash_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= '0;
         squash_q <= '0;
      end else begin
         stall_q  <= stall_q + {31'd0, stall_inc_i};
         squash_q <= squash_q + {31'd0, squash_inc_i};
      end
   end
   assign stall_cnt_o  = stall_q;
   assign squash_cnt_o = squash_q;
endmodule

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: F->D pipeline register with AdEL detection, stall, flush and eret squash.
// Counters exist only when FD_PERF_CNT_EN is defined; otherwise they read 0.
module fetch_decode_reg
   import fetch_decode_reg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        req,
   input  logic        eretD,
   input  logic [31:0] pcF,
   input  logic [31:0] instrF,
   input  logic        bdF,
   output logic [31:0] pcD,
   output logic [31:0] instrD,
   output logic [4:0]  excCodeD,
   output logic        bdD,
   output logic        validD,
   output logic [31:0] stallCnt,
   output logic [31:0] squashCnt
);
   logic [31:0] pc_q, pc_d, instr_q, instr_d;
   logic [4:0]  exc_q, exc_d;
   logic        bd_q, bd_d, valid_q, valid_d, adel;
   // req overrides a stall; eretD only matters when the stage advances
   always_comb begin
      adel    = fetch_adel(pcF);
      pc_d    = req ? EXC_VEC : en ? pcF : pc_q;
      instr_d = req ? NOP : !en ? instr_q : (eretD || adel) ? NOP : instrF;
      exc_d   = req ? EXC_INT : !en ? exc_q : (eretD || !adel) ? EXC_INT : EXC_ADEL;
      bd_d    = req ? 1'b0 : !en ? bd_q : (!eretD && bdF);
      valid_d = req ? 1'b0 : !en ? valid_q : !eretD;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= IM_BASE;
         instr_q <= NOP;
         exc_q   <= EXC_INT;
         bd_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         exc_q   <= exc_d;
         bd_q    <= bd_d;
         valid_q <= valid_d;
      end
   end
   assign pcD      = pc_q;
   assign instrD   = instr_q;
   assign excCodeD = exc_q;
   assign bdD      = bd_q;
   assign validD   = valid_q;
`ifdef FD_PERF_CNT_EN
   fd_perf_cnt u_perf (
      .clk          (clk),
      .reset        (reset),
      .stall_inc_i  (!en && !req),
      .squash_inc_i (req || (en && eretD)),
      .stall_cnt_o  (stallCnt),
      .squash_cnt_o (squashCnt)
   );
`else
   assign stallCnt  = '0;
   assign squashCnt = '0;
`endif
endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb_fetch_decode_reg: directed self-checking bench for fetch_decode_reg
module tb_fetch_decode_reg;
`ifdef FD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic        clk = 1'b0, reset = 1'b1, en = 1'b0, req = 1'b0, eretD = 1'b0, bdF = 1'b0;
   logic [31:0] pcF = 32'h0, instrF = 32'h0;
   logic [31:0] pcD, instrD, stallCnt, squashCnt;
   logic [4:0]  excCodeD;
   logic        bdD, validD;
   int          checks = 0, errors = 0;

   fetch_decode_reg dut (
      .clk(clk), .reset(reset), .en(en), .req(req), .eretD(eretD),
      .pcF(pcF), .instrF(instrF), .bdF(bdF),
      .pcD(pcD), .instrD(instrD), .excCodeD(excCodeD), .bdD(bdD), .validD(validD),
      .stallCnt(stallCnt), .squashCnt(squashCnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic cnts(input string tag, input int s, input int q);
      chk({tag, "_stallCnt"}, stallCnt, PERF ? 32'(s) : 32'h0);
      chk({tag, "_squashCnt"}, squashCnt, PERF ? 32'(q) : 32'h0);
   endtask

   initial begin
      step;
      chk("rst_pcD", pcD, 32'h3000);
      chk("rst_instrD", instrD, 32'h0);
      chk("rst_exc", {27'd0, excCodeD}, 32'd0);
      chk("rst_bdD", {31'd0, bdD}, 32'd0);
      chk("rst_validD", {31'd0, validD}, 32'd0);
      cnts("rst", 0, 0);

      reset = 1'b0; en = 1'b1; pcF = 32'h3000; instrF = 32'h3C010001;
      step;
      chk("load_pcD", pcD, 32'h3000);
      chk("load_instrD", instrD, 32'h3C010001);
      chk("load_validD", {31'd0, validD}, 32'd1);
      chk("load_exc", {27'd0, excCodeD}, 32'd0);

      en = 1'b0; pcF = 32'h3004; instrF = 32'h1111_1111; step;
      pcF = 32'h3008; step;
      step;
      chk("stall_pcD", pcD, 32'h3000);
      chk("stall_instrD", instrD, 32'h3C010001);
      cnts("stall", 3, 0);

      en = 1'b1; pcF = 32'h3002; instrF = 32'h2222_2222; step;
      chk("mis_exc", {27'd0, excCodeD}, 32'd4);
      chk("mis_instrD", instrD, 32'h0);
      chk("mis_pcD", pcD, 32'h3002);
      chk("mis_validD", {31'd0, validD}, 32'd1);
      pcF = 32'h2FFC; step;
      chk("low_exc", {27'd0, excCodeD}, 32'd4);
      pcF = 32'h7000; step;
      chk("high_exc", {27'd0, excCodeD}, 32'd4);
      pcF = 32'h6FFC; instrF = 32'h3333_3333; step;
      chk("limit_exc", {27'd0, excCodeD}, 32'd0);
      chk("limit_instrD", instrD, 32'h3333_3333);

      req = 1'b1; en = 1'b0; bdF = 1'b1; step;
      chk("req_pcD", pcD, 32'h4180);
      chk("req_instrD", instrD, 32'h0);
      chk("req_validD", {31'd0, validD}, 32'd0);
      chk("req_bdD", {31'd0, bdD}, 32'd0);
      cnts("req", 3, 1);

      req = 1'b0; bdF = 1'b0; en = 1'b1; eretD = 1'b1; pcF = 32'h3010; instrF = 32'h4444_4444; step;
      chk("eret_instrD", instrD, 32'h0);
      chk("eret_exc", {27'd0, excCodeD}, 32'd0);
      chk("eret_validD", {31'd0, validD}, 32'd0);
      chk("eret_pcD", pcD, 32'h3010);
      pcF = 32'h3011; step;
      chk("eret_mis_exc", {27'd0, excCodeD}, 32'd0);
      chk("eret_mis_pcD", pcD, 32'h3011);
      cnts("eret", 3, 3);
      en = 1'b0; pcF = 32'h3050; step;
      chk("eret_hold_pcD", pcD, 32'h3011);
      cnts("eret_hold", 4, 3);

      eretD = 1'b0; en = 1'b1; bdF = 1'b1; pcF = 32'h3020; instrF = 32'h5555_5555; step;
      chk("bd_bdD", {31'd0, bdD}, 32'd1);
      chk("bd_validD", {31'd0, validD}, 32'd1);
      chk("bd_pcD", pcD, 32'h3020);

      reset = 1'b1; req = 1'b1; step;
      chk("rstreq_pcD", pcD, 32'h3000);
      chk("rstreq_validD", {31'd0, validD}, 32'd0);
      chk("rstreq_bdD", {31'd0, bdD}, 32'd0);
      cnts("rstreq", 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
